// File: rtl/mix_w_writer.sv
// Write-side sequencer for the mix-layer weight RAM; optional abort port under MIX_W_WRITER_ABORT_EN.
// Latency: a beat accepted in cycle N drives load/waddr/wdata in cycle N+1.
// Backpressure: s_ready is high for every WRITE cycle and low in IDLE; s_valid bubbles stall the address counter.
`ifndef HID_DIM
`define HID_DIM 24
`endif
`ifndef DATA_N
`define DATA_N 8
`endif
`ifndef N_LEN_W
`define N_LEN_W 16
`endif

module mix_w_writer #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = `DATA_N*`N_LEN_W,
  parameter int SEC_DEPTH  = `HID_DIM*`HID_DIM/`DATA_N,
  parameter int DATA_DEPTH = 3*SEC_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [1:0]            sel,
`ifdef MIX_W_WRITER_ABORT_EN
  input  logic                  abort,
`endif
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  load,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic                  busy,
  output logic                  done
);

  localparam logic [ADDR_WIDTH-1:0] SEC_A    = ADDR_WIDTH'(SEC_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ALL = ADDR_WIDTH'(DATA_DEPTH - 1);

  typedef enum logic {IDLE, WRITE} state_t;

  typedef struct packed {
    logic                  load;
    logic [ADDR_WIDTH-1:0] waddr;
    logic [DATA_WIDTH-1:0] wdata;
  } wr_t;

  state_t                state, state_n;
  logic [ADDR_WIDTH-1:0] addr, addr_n;
  logic [ADDR_WIDTH-1:0] last, last_n;
  logic [ADDR_WIDTH-1:0] base;
  wr_t                   wr, wr_n;
  logic                  busy_q, busy_n;
  logic                  done_q, done_n;
  logic                  accept;
  logic                  stop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      addr   <= '0;
      last   <= '0;
      wr     <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_n;
      addr   <= addr_n;
      last   <= last_n;
      wr     <= wr_n;
      busy_q <= busy_n;
      done_q <= done_n;
    end
  end

  // Section base from the requested selector; sel==3 spans the whole RAM.
  always_comb begin
    base = '0;
    case (sel)
      2'd1:    base = SEC_A;
      2'd2:    base = SEC_A + SEC_A;
      default: base = '0;
    endcase
  end

`ifdef MIX_W_WRITER_ABORT_EN
  assign stop = abort;
`else
  assign stop = 1'b0;
`endif

  assign s_ready = (state == WRITE);
  assign accept  = s_valid && s_ready;

  always_comb begin
    state_n  = state;
    addr_n   = addr;
    last_n   = last;
    wr_n     = wr;
    wr_n.load = 1'b0;
    done_n   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          addr_n  = base;
          last_n  = (sel == 2'd3) ? LAST_ALL : base + SEC_A - ADDR_WIDTH'(1);
          state_n = WRITE;
        end
      end
      WRITE: begin
        if (accept) begin
          wr_n.load  = 1'b1;
          wr_n.waddr = addr;
          wr_n.wdata = s_data;
          addr_n     = addr + ADDR_WIDTH'(1);
          if (addr == last) begin
            state_n = IDLE;
            done_n  = 1'b1;
          end
        end
        // An abort still lets a same-cycle beat land but never reports completion.
        if (stop) begin
          state_n = IDLE;
          done_n  = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase
    busy_n = (state_n == WRITE);
  end

  assign load  = wr.load;
  assign waddr = wr.waddr;
  assign wdata = wr.wdata;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: doc/mix_w_writer.md
Name: mix_w_writer

Overview:
- Write-side sequencer for the mix-layer weight RAM.
- Accepts a valid/ready stream of packed weight words from the optimizer/update path.
- Drives the RAM write port (load/waddr/wdata) over one weight section (W_1, W_2, W_3) or all three back-to-back.
- Reports busy/done to the training controller.

Parameters:
- ADDR_WIDTH, 9, RAM address width.
- DATA_WIDTH, `DATA_N*`N_LEN_W, packed word width (DATA_N lanes of N_LEN_W bits).
- SEC_DEPTH, `HID_DIM*`HID_DIM/`DATA_N, words per weight section.
- DATA_DEPTH, 3*SEC_DEPTH, total RAM words.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to begin a write pass; sampled only in IDLE.
- sel  in  2  captured with start. 0/1/2 = W_1/W_2/W_3 section only; 3 = all sections, addresses 0..DATA_DEPTH-1.
- s_valid  in  1  input word valid.
- s_ready  out  1  writer can accept a word.
- s_data  in  DATA_WIDTH  input word.
- load  out  1  RAM write enable.
- waddr  out  ADDR_WIDTH  RAM write address.
- wdata  out  DATA_WIDTH  RAM write data.
- busy  out  1  high while a pass is in progress.
- done  out  1  one-cycle pulse at the end of a pass.

Behaviour:
- Reset (async, active-high): state=IDLE; load=0, waddr=0, wdata=0, busy=0, done=0, internal address counter=0.
- FSM states: IDLE, WRITE.
- IDLE:
  - s_ready=0.
  - On start=1, capture sel and compute:
    - base = (sel==3) ? 0 : sel*SEC_DEPTH.
    - last = (sel==3) ? DATA_DEPTH-1 : base+SEC_DEPTH-1.
  - Set addr=base, busy=1 and go to WRITE next cycle.
- WRITE:
  - s_ready=1 (combinational from state; no dependency on s_valid).
  - A beat is accepted when s_valid&&s_ready.
  - Latency on an accepted beat in cycle N: in cycle N+1, load=1, waddr=addr(N), wdata=s_data(N). Then addr=addr+1.
  - No accept: load=0 next cycle; waddr/wdata hold their previous values.
  - Bubbles of any length are allowed. Address advances only on accepts.
  - Accept with addr==last: go to IDLE. In cycle N+1, done=1 coincident with the final load=1, and busy=0.
- done is high for exactly one cycle per completed pass. load never exceeds one pulse per accepted beat.
- start while busy is ignored; sel changes mid-pass are ignored.
- start in the same cycle done is high is legal: IDLE samples it, and the next pass begins the following cycle.
- Address arithmetic is unsigned ADDR_WIDTH. The counter never passes last, so no wrap is possible.
- Reset asserted mid-pass: return to IDLE immediately, load drops asynchronously, and done is not pulsed. A partially written section keeps whatever words were written.
- Write ordering matches the RAM's $readmemb section layout: W_1 at 0..SEC_DEPTH-1, W_2 next, then W_3.

Optional Feature:
- MIX_W_WRITER_ABORT_EN defined:
  - Adds an input port abort (1 bit).
  - abort=1 in WRITE: go to IDLE next cycle, s_ready=0 from that cycle, busy=0, done=0.
  - A beat accepted in the same cycle as abort is still written (load=1 next cycle). No further beats are accepted.
  - abort in IDLE has no effect.
- Not defined: no abort port; a pass ends only on completion or reset.

Test Plan:
- Bench config: HID_DIM=24, DATA_N=8, so SEC_DEPTH=72 and DATA_DEPTH=216.
- Reset check: after rst, load=0, waddr=0, busy=0, done=0, s_ready=0.
- start with sel=1, 72 back-to-back beats with data=addr -> waddr runs 72..143 with load every cycle; done=1 with the waddr=143 write; RAM readback matches.
- sel=3 with random s_valid bubbles (~50%) -> exactly 216 load pulses, addresses 0..215 in order, no gaps or repeats, and a single done.
- start pulsed again mid-pass (sel=0) -> ignored; pass completes on the original section and done count is 1.
- rst asserted after 10 accepted beats of sel=2 -> immediate IDLE, no done; a new start with sel=2 restarts at waddr=144.
- MIX_W_WRITER_ABORT_EN: abort coincident with beat 5 of sel=0 -> beats 0..5 are written, s_ready=0 next cycle, no done; with the macro undefined, the abort port is absent.
